// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ula_pkg
// Description : Shared definitions for the ULA result stage. Holds the
//               opcode encodings, the condition-flag bit positions, the
//               default datapath widths and the packed result-entry type
//               carried through the result buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package ula_pkg;

    // Default datapath widths; must track the ULA data width.
    localparam int ULA_DATA_W = 32;
    localparam int ULA_TAG_W  = 5;
    localparam int OP_W       = 4;
    localparam int FLAGS_W    = 3;

    // ULASelect encodings.
    localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OP_W-1:0] OP_AND = 4'b0011;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_NOT = 4'b0101;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0110;
    localparam logic [OP_W-1:0] OP_SHR = 4'b0111;
    localparam logic [OP_W-1:0] OP_SHL = 4'b1000;

    // Bit positions inside the {V,N,Z} flag vector.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

    // One buffered result at the default widths.
    typedef struct packed {
        logic [ULA_DATA_W-1:0] result;
        logic [FLAGS_W-1:0]    flags;
        logic [OP_W-1:0]       op;
        logic [ULA_TAG_W-1:0]  tag;
    } ula_entry_t;

    // Overflow is only meaningful for arithmetic opcodes; every other code,
    // including NOP and undefined codes above SHL, reports V=0.
    function automatic logic ovf_qualifies(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage : ula_pkg
`default_nettype wire

// File: rtl/ula_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : ula_skid_buf
// Description : Generic 2-entry in-order valid/ready buffer. Both o_ready
//               and o_valid come straight from flops, so neither side sees
//               a combinational path through the other's handshake.
//   clk       in   clock, all state on rising edge
//   rst       in   synchronous active-high reset, discards both entries
//   i_data    in   WIDTH  entry to push
//   i_valid   in   push request
//   o_ready   out  buffer can accept (registered)
//   o_data    out  WIDTH  head entry
//   o_valid   out  head valid (registered)
//   i_ready   in   consumer takes the head
// Revision    : 1.0 - initial release
// ============================================================================
module ula_skid_buf #(
    parameter int WIDTH = 44
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             r_out_valid;
    logic             r_in_ready;

    logic             w_push;
    logic             w_pop;

    assign w_push = i_valid & r_in_ready;
    assign w_pop  = r_out_valid & i_ready;

    // The head register always drives the outputs; the tail only holds the
    // second entry while FULL. Head is left untouched on a pop to EMPTY so
    // outputs never toggle without a new entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_EMPTY;
            r_head      <= '0;
            r_tail      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_push) begin
                        r_head      <= i_data;
                        r_state     <= c_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                c_ONE: begin
                    if (w_push && !w_pop) begin
                        r_tail     <= i_data;
                        r_state    <= c_FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_pop && !w_push) begin
                        r_state     <= c_EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (w_push && w_pop) begin
                        // Head leaves, new entry takes its place.
                        r_head <= i_data;
                    end
                end
                c_FULL: begin
                    if (w_pop) begin
                        r_head     <= r_tail;
                        r_state    <= c_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = r_in_ready;
    assign o_valid = r_out_valid;
    assign o_data  = r_head;

endmodule : ula_skid_buf
`default_nettype wire

// File: rtl/ula_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : ula_result_stage
// Description : Registered output stage behind the combinational ULA.
//               Derives {V,N,Z} from each accepted result and queues
//               result/flags/opcode/tag in a 2-entry buffer presented to
//               writeback through a valid/ready handshake.
//   Clock       in   clock
//   Reset       in   synchronous active-high reset
//   ResultIn    in   DATA_W  ULA DataOut
//   OverflowIn  in   ULA overflow
//   OpIn        in   4       ULASelect of ResultIn
//   TagIn       in   TAG_W   destination tag
//   InValid     in   upstream entry valid
//   InReady     out  stage can accept (registered)
//   ResultOut   out  DATA_W  head result
//   FlagsOut    out  3       head {V,N,Z}
//   OpOut       out  4       head opcode
//   TagOut      out  TAG_W   head tag
//   OutValid    out  head valid
//   OutReady    in   consumer accepts head
//   StickyOvf   out  sticky overflow     (ULA_STICKY_OVF_EN only)
//   ClearSticky in   clear sticky flag   (ULA_STICKY_OVF_EN only)
// Build option: define ULA_STICKY_OVF_EN to add the sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_result_stage
    import ula_pkg::*;
#(
    parameter int DATA_W = ULA_DATA_W,
    parameter int TAG_W  = ULA_TAG_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [DATA_W-1:0]  ResultIn,
    input  logic               OverflowIn,
    input  logic [OP_W-1:0]    OpIn,
    input  logic [TAG_W-1:0]   TagIn,
    input  logic               InValid,
    output logic               InReady,
    output logic [DATA_W-1:0]  ResultOut,
    output logic [FLAGS_W-1:0] FlagsOut,
    output logic [OP_W-1:0]    OpOut,
    output logic [TAG_W-1:0]   TagOut,
    output logic               OutValid,
    input  logic               OutReady
`ifdef ULA_STICKY_OVF_EN
    ,
    output logic               StickyOvf,
    input  logic               ClearSticky
`endif
);

    // Same layout as ula_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0]  result;
        logic [FLAGS_W-1:0] flags;
        logic [OP_W-1:0]    op;
        logic [TAG_W-1:0]   tag;
    } entry_t;

    localparam int c_ENTRY_W = $bits(entry_t);

    entry_t w_in_entry;
    entry_t w_out_entry;
    logic   w_in_ready;
    logic   w_out_valid;

    // Flags are fixed at push time and travel with the entry.
    always_comb begin
        w_in_entry                = '0;
        w_in_entry.result         = ResultIn;
        w_in_entry.op             = OpIn;
        w_in_entry.tag            = TagIn;
        w_in_entry.flags[FLAG_Z]  = (ResultIn == '0);
        w_in_entry.flags[FLAG_N]  = ResultIn[DATA_W-1];
        w_in_entry.flags[FLAG_V]  = OverflowIn & ovf_qualifies(OpIn);
    end

    ula_skid_buf #(
        .WIDTH (c_ENTRY_W)
    ) u_skid_buf (
        .clk     (Clock),
        .rst     (Reset),
        .i_data  (w_in_entry),
        .i_valid (InValid),
        .o_ready (w_in_ready),
        .o_data  (w_out_entry),
        .o_valid (w_out_valid),
        .i_ready (OutReady)
    );

    assign InReady   = w_in_ready;
    assign OutValid  = w_out_valid;
    assign ResultOut = w_out_entry.result;
    assign FlagsOut  = w_out_entry.flags;
    assign OpOut     = w_out_entry.op;
    assign TagOut    = w_out_entry.tag;

`ifdef ULA_STICKY_OVF_EN
    logic r_sticky_ovf;
    logic w_pop_ovf;

    assign w_pop_ovf = w_out_valid & OutReady & w_out_entry.flags[FLAG_V];

    // Setting takes priority over clearing in the same cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_sticky_ovf <= 1'b0;
        end else if (w_pop_ovf) begin
            r_sticky_ovf <= 1'b1;
        end else if (ClearSticky) begin
            r_sticky_ovf <= 1'b0;
        end
    end

    assign StickyOvf = r_sticky_ovf;
`endif

endmodule : ula_result_stage
`default_nettype wire

// File: tb/tb_ula_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_result_stage
// Description : Self-checking bench for ula_result_stage. A queue-based
//               reference holds the expected buffered entries; flags are
//               computed from the arithmetic rules on the raw inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_result_stage;

    localparam int DW = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] res_in;
    logic          ovf_in;
    logic [3:0]    op_in;
    logic [TW-1:0] tag_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] res_out;
    logic [2:0]    flags_out;
    logic [3:0]    op_out;
    logic [TW-1:0] tag_out;
    logic          out_valid;
    logic          out_ready;
`ifdef ULA_STICKY_OVF_EN
    logic          sticky_ovf;
    logic          clear_sticky;
    bit            m_sticky;
`endif

    typedef struct {
        logic [DW-1:0] r;
        logic [2:0]    f;
        logic [3:0]    op;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ula_result_stage #(
        .DATA_W (DW),
        .TAG_W  (TW)
    ) dut (
        .Clock       (clk),
        .Reset       (rst),
        .ResultIn    (res_in),
        .OverflowIn  (ovf_in),
        .OpIn        (op_in),
        .TagIn       (tag_in),
        .InValid     (in_valid),
        .InReady     (in_ready),
        .ResultOut   (res_out),
        .FlagsOut    (flags_out),
        .OpOut       (op_out),
        .TagOut      (tag_out),
        .OutValid    (out_valid),
        .OutReady    (out_ready)
`ifdef ULA_STICKY_OVF_EN
        ,
        .StickyOvf   (sticky_ovf),
        .ClearSticky (clear_sticky)
`endif
    );

    function automatic exp_t ref_entry(input logic [DW-1:0] r, input logic ovf,
                                       input logic [3:0] op, input logic [TW-1:0] tag);
        exp_t e;
        logic z, n, v;
        z     = (r == 0);
        n     = (r >= 32'h8000_0000);
        v     = ovf && (op == 4'd1 || op == 4'd2);
        e.r   = r;
        e.f   = {v, n, z};
        e.op  = op;
        e.tag = tag;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk("result", {32'd0, res_out}, {32'd0, q[0].r});
            chk("flags", {61'd0, flags_out}, {61'd0, q[0].f});
            chk("op", {60'd0, op_out}, {60'd0, q[0].op});
            chk("tag", {59'd0, tag_out}, {59'd0, q[0].tag});
        end
`ifdef ULA_STICKY_OVF_EN
        chk("sticky", {63'd0, sticky_ovf}, {63'd0, m_sticky});
`endif
    endtask

    // Advance one clock, update the reference from the inputs seen at the
    // edge, then compare 1 time unit after the edge.
    task automatic step();
        exp_t e;
        bit   push, pop, popv, clr;
        e    = ref_entry(res_in, ovf_in, op_in, tag_in);
        push = in_valid && (q.size() < 2);
        pop  = out_ready && (q.size() > 0);
        popv = pop && q[0].f[2];
        clr  = 1'b0;
`ifdef ULA_STICKY_OVF_EN
        clr  = clear_sticky;
`endif
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
`ifdef ULA_STICKY_OVF_EN
            m_sticky = 1'b0;
`endif
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
`ifdef ULA_STICKY_OVF_EN
            if (popv) m_sticky = 1'b1;
            else if (clr) m_sticky = 1'b0;
`else
            if (popv && clr) begin end
`endif
        end
        check_state();
    endtask

    task automatic drive(input logic [DW-1:0] r, input logic ovf,
                         input logic [3:0] op, input logic [TW-1:0] tag);
        res_in   = r;
        ovf_in   = ovf;
        op_in    = op;
        tag_in   = tag;
        in_valid = 1'b1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_result", {32'd0, res_out}, 64'd0);
        chk("rst_flags", {61'd0, flags_out}, 64'd0);
        chk("rst_op", {60'd0, op_out}, 64'd0);
        chk("rst_tag", {59'd0, tag_out}, 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        res_in    = '0;
        ovf_in    = 1'b0;
        op_in     = '0;
        tag_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef ULA_STICKY_OVF_EN
        clear_sticky = 1'b0;
        m_sticky     = 1'b0;
`endif

        // Reset state
        step();
        step();
        check_reset_outputs();
        rst = 1'b0;

        // Zero result, AND opcode: Z only; empties the cycle after
        out_ready = 1'b1;
        drive(32'h0, 1'b0, 4'b0011, 5'd7);
        step();
        in_valid = 1'b0;
        chk("zero_flags", {61'd0, flags_out}, 64'b001);
        step();

        // Negative with overflow on ADD: V and N
        drive(32'h8000_0000, 1'b1, 4'b0001, 5'd3);
        step();
        in_valid = 1'b0;
        chk("add_ovf_flags", {61'd0, flags_out}, 64'b110);
        step();

        // Same value on XOR: overflow ignored
        drive(32'h8000_0000, 1'b1, 4'b0110, 5'd4);
        step();
        in_valid = 1'b0;
        chk("xor_flags", {61'd0, flags_out}, 64'b010);
        step();

        // NOP and an undefined code pass through with V forced low
        drive(32'h1234_5678, 1'b1, 4'b0000, 5'd9);
        step();
        drive(32'hFFFF_0000, 1'b1, 4'b1101, 5'd10);
        step();
        in_valid = 1'b0;
        step();
        step();

        // Backpressure: tags 1,2 fill the buffer, tag 3 held until accepted
        out_ready = 1'b0;
        drive(32'd11, 1'b0, 4'b0100, 5'd1);
        step();
        drive(32'd22, 1'b0, 4'b0100, 5'd2);
        step();
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        drive(32'd33, 1'b0, 4'b0100, 5'd3);
        step();
        step();
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();

        // Streaming 100 random entries
        for (int i = 0; i < 100; i++) begin
            drive((i % 7 == 0) ? 32'h0 : $urandom, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Random handshake mix
        for (int i = 0; i < 80; i++) begin
            drive($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  5'($urandom_range(0, 31)));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end

        // Reset while FULL discards both entries
        out_ready = 1'b0;
        drive(32'hAAAA_5555, 1'b1, 4'b0010, 5'd21);
        step();
        drive(32'h5555_AAAA, 1'b0, 4'b0001, 5'd22);
        step();
        step();
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        check_reset_outputs();
        rst      = 1'b0;
        in_valid = 1'b0;
        step();

`ifdef ULA_STICKY_OVF_EN
        // Sticky overflow: set on V=1 pop, hold on V=0 pops, set beats clear
        out_ready = 1'b1;
        drive(32'h7FFF_FFFF, 1'b1, 4'b0001, 5'd1);
        step();
        in_valid = 1'b0;
        step();
        chk("sticky_set", {63'd0, sticky_ovf}, 64'd1);
        drive(32'h1, 1'b0, 4'b0010, 5'd2);
        step();
        in_valid = 1'b0;
        step();
        chk("sticky_hold", {63'd0, sticky_ovf}, 64'd1);
        drive(32'h2, 1'b1, 4'b0010, 5'd3);
        step();
        in_valid     = 1'b0;
        clear_sticky = 1'b1;
        step();
        chk("sticky_set_wins", {63'd0, sticky_ovf}, 64'd1);
        step();
        clear_sticky = 1'b0;
        chk("sticky_clear", {63'd0, sticky_ovf}, 64'd0);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ula_result_stage
`default_nettype wire
